// File: rtl/motor_sequencer.sv
// Command sequencer in front of motor_contoller: one-hot motor drive with dwell, stop gap and
// fixed rotate. Obstacle-driven emergency stop is compiled in when MOTOR_SEQ_OBSTACLE_EN is defined.
module motor_sequencer #(
    parameter int unsigned DWELL_CYCLES  = 16,
    parameter int unsigned GAP_CYCLES    = 4,
    parameter int unsigned ROTATE_CYCLES = 32,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] nav_cmd,
    input  logic       nav_valid,
    output logic       nav_ready,
    input  logic       obstacle,
    output logic       stop_motor,
    output logic       front_motor,
    output logic       turn_left,
    output logic       turn_right,
    output logic       rotate,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRun  = 3'd1,
        StGap  = 3'd2,
        StRot  = 3'd3,
        StHalt = 3'd4
    } state_e;

    localparam logic [2:0] CmdStop   = 3'd0;
    localparam logic [2:0] CmdFront  = 3'd1;
    localparam logic [2:0] CmdLeft   = 3'd2;
    localparam logic [2:0] CmdRight  = 3'd3;
    localparam logic [2:0] CmdRotate = 3'd4;

    localparam logic [CNT_W-1:0] DwellVal = CNT_W'(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] GapLast  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RotLast  = CNT_W'(ROTATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       cur_q, cur_d;
    logic [2:0]       pend_q, pend_d;
    logic [2:0]       cmd;
    logic             ready_raw;
    logic             accept;

    assign cmd    = (nav_cmd > CmdRotate) ? CmdStop : nav_cmd;
    assign state  = state_q;
    assign accept = nav_valid & nav_ready;

    always_comb begin
        ready_raw = 1'b0;
        case (state_q)
            StIdle:  ready_raw = 1'b1;
            StRun:   ready_raw = (cnt_q == DwellVal);
            default: ready_raw = 1'b0;
        endcase
`ifdef MOTOR_SEQ_OBSTACLE_EN
        nav_ready = ready_raw & ~reset & ~obstacle;
`else
        nav_ready = ready_raw & ~reset;
`endif
    end

`ifndef MOTOR_SEQ_OBSTACLE_EN
    logic unused_obstacle;
    assign unused_obstacle = obstacle;
`endif

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        pend_d  = pend_q;
        // RUN holds cnt at the dwell value so an idle nav side never locks ready out.
        if (state_q == StRun) begin
            cnt_d = (cnt_q >= DwellVal) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (cmd == CmdFront || cmd == CmdLeft || cmd == CmdRight) begin
                        state_d = StRun;
                        cur_d   = cmd;
                        cnt_d   = '0;
                    end else if (cmd == CmdRotate) begin
                        state_d = StRot;
                        cnt_d   = '0;
                    end
                end
            end
            StRun: begin
                if (accept && cmd != cur_q) begin
                    cnt_d = '0;
                    if (cmd == CmdStop) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StGap;
                        pend_d  = cmd;
                    end
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d = '0;
                    if (pend_q == CmdRotate) begin
                        state_d = StRot;
                    end else begin
                        state_d = StRun;
                        cur_d   = pend_q;
                    end
                end
            end
            StRot: begin
                if (cnt_q == RotLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
`ifdef MOTOR_SEQ_OBSTACLE_EN
            StHalt: begin
                if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
`endif
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

`ifdef MOTOR_SEQ_OBSTACLE_EN
        // Obstacle beats every other transition; HALT keeps cnt at 0 while it persists.
        if (obstacle) begin
            state_d = StHalt;
            cnt_d   = '0;
            pend_d  = CmdStop;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cur_q       <= CmdStop;
            pend_q      <= CmdStop;
            stop_motor  <= 1'b1;
            front_motor <= 1'b0;
            turn_left   <= 1'b0;
            turn_right  <= 1'b0;
            rotate      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            pend_q      <= pend_d;
            stop_motor  <= (state_d == StIdle) || (state_d == StGap) || (state_d == StHalt);
            front_motor <= (state_d == StRun) && (cur_d == CmdFront);
            turn_left   <= (state_d == StRun) && (cur_d == CmdLeft);
            turn_right  <= (state_d == StRun) && (cur_d == CmdRight);
            rotate      <= (state_d == StRot);
        end
    end

endmodule

// File: tb/tb_motor_sequencer.sv
// Randomized scoreboard bench for motor_sequencer; a timeline-based reference model predicts
// state, motor drive and nav_ready for every cycle.
module tb_motor_sequencer;

    localparam int DWELL = 4;
    localparam int GAP   = 2;
    localparam int ROT   = 6;
    localparam int NCYC  = 4000;
`ifdef MOTOR_SEQ_OBSTACLE_EN
    localparam bit OBS_EN = 1'b1;
`else
    localparam bit OBS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] nav_cmd = 3'd0;
    logic       nav_valid = 1'b0;
    logic       nav_ready;
    logic       obstacle = 1'b0;
    logic       stop_motor, front_motor, turn_left, turn_right, rotate;
    logic [2:0] state;
    logic [4:0] mot;

    assign mot = {stop_motor, front_motor, turn_left, turn_right, rotate};

    always #5 clk = ~clk;

    motor_sequencer #(
        .DWELL_CYCLES (DWELL),
        .GAP_CYCLES   (GAP),
        .ROTATE_CYCLES(ROT),
        .CNT_W        (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .nav_cmd    (nav_cmd),
        .nav_valid  (nav_valid),
        .nav_ready  (nav_ready),
        .obstacle   (obstacle),
        .stop_motor (stop_motor),
        .front_motor(front_motor),
        .turn_left  (turn_left),
        .turn_right (turn_right),
        .rotate     (rotate),
        .state      (state)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [4:0] mot;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];
    exp_t sched[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Model: a queue of forced segments (gap/rotate/halt) followed by a steady IDLE or RUN.
    bit   steady_run = 1'b0;
    int   steady_cmd = 0;
    int   run_age = 0;

    function automatic exp_t seg(int st, logic [4:0] m);
        exp_t e;
        e.st  = 3'(st);
        e.mot = m;
        e.rdy = 1'b0;
        return e;
    endfunction

    function automatic exp_t run_seg(int c);
        return seg(1, (c == 1) ? 5'b01000 : (c == 2) ? 5'b00100 : 5'b00010);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0) begin
                chk("sb_empty", 0, 1);
            end else begin
                e = exp_q.pop_front();
                chk("state", int'(state), int'(e.st));
                chk("motor", int'(mot), int'(e.mot));
                chk("nav_ready", int'(nav_ready), int'(e.rdy));
            end
        end
    end

    initial begin : driver
        int   rst_left = 0;
        int   obs_left = 0;
        logic [2:0] last_cmd = 3'd1;
        exp_t cur_e;
        bit   is_idle, is_run, obs_eff, acc;
        int   c;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc < 2) begin
                rst_left = 0;
                reset = 1'b1;
            end else begin
                if (rst_left == 0 && $urandom_range(149, 0) == 0) rst_left = $urandom_range(3, 1);
                reset = (rst_left != 0);
                if (rst_left != 0) rst_left--;
            end
            if (obs_left == 0 && $urandom_range(59, 0) == 0) obs_left = $urandom_range(5, 1);
            obstacle = (obs_left != 0);
            if (obs_left != 0) obs_left--;
            nav_valid = ($urandom_range(99, 0) < 60);
            if ($urandom_range(1, 0) == 1) nav_cmd = last_cmd;
            else nav_cmd = 3'($urandom_range(7, 0));
            last_cmd = nav_cmd;

            is_idle = (sched.size() == 0) && !steady_run;
            is_run  = (sched.size() == 0) && steady_run;
            if (sched.size() != 0) cur_e = sched[0];
            else if (steady_run) cur_e = run_seg(steady_cmd);
            else cur_e = seg(0, 5'b10000);
            obs_eff   = OBS_EN && obstacle;
            cur_e.rdy = !reset && !obs_eff && (is_idle || (is_run && run_age >= DWELL));
            exp_q.push_back(cur_e);

            acc = nav_valid && cur_e.rdy;
            c   = (nav_cmd > 3'd4) ? 0 : int'(nav_cmd);
            if (reset) begin
                sched.delete();
                steady_run = 1'b0;
            end else if (obs_eff) begin
                sched.delete();
                repeat (GAP) sched.push_back(seg(4, 5'b10000));
                steady_run = 1'b0;
            end else begin
                if (sched.size() != 0) void'(sched.pop_front());
                else if (is_run) run_age++;
                if (acc && is_idle) begin
                    if (c >= 1 && c <= 3) begin
                        steady_run = 1'b1;
                        steady_cmd = c;
                        run_age    = 0;
                    end else if (c == 4) begin
                        repeat (ROT) sched.push_back(seg(3, 5'b00001));
                    end
                end else if (acc && is_run && c != steady_cmd) begin
                    if (c == 0) begin
                        steady_run = 1'b0;
                    end else begin
                        repeat (GAP) sched.push_back(seg(2, 5'b10000));
                        if (c == 4) begin
                            repeat (ROT) sched.push_back(seg(3, 5'b00001));
                            steady_run = 1'b0;
                        end else begin
                            steady_cmd = c;
                            run_age    = 0;
                        end
                    end
                end
            end
        end
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
